fir_sample_sched: RTL and testbench

Sample scheduler that sits directly upstream of the serial distributed-arithmetic FIR core. Producers push parallel samples through a valid/ready handshake into a small FIFO. The scheduler pops one sample at a time, presents it on `fir_x` with a one-cycle `fir_start` pulse, and waits for the core's `fir_done` pulse before issuing the next sample. This absorbs producer burstiness, so the core only ever sees a start when it is idle.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_sample_sched_if.sv | 23 ++
 rtl/fir_sample_sched_sync_fifo.sv | 54 +++++
 rtl/fir_sample_sched.sv | 142 ++++++++++++++
 tb/tb_fir_sample_sched.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sample scheduler: FSM state encoding,
// completion-counter width and the FIFO pointer-width helper.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } sched_state_e;

  localparam int OUT_CNT_W = 16;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_DEPTH = 4;
  localparam int DEF_PTR_W = ptr_w(DEF_DEPTH);

endpackage

// File: rtl/fir_sample_sched_if.sv
// Producer push handshake plus the start/sample/done link to the FIR core.
interface fir_sample_sched_if #(
  parameter int BITS = 8
) ();

  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic            fir_start;
  logic [BITS-1:0] fir_x;
  logic            fir_done;

  modport master (
    output in_valid, in_data, fir_done,
    input  in_ready, fir_start, fir_x
  );

  modport slave (
    input  in_valid, in_data, fir_done,
    output in_ready, fir_start, fir_x
  );

endinterface

// File: rtl/fir_sample_sched_sync_fifo.sv
// Single-clock sample FIFO with wrap-bit pointers; push/pop are assumed
// already qualified by the caller against full/empty.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [BITS-1:0]           wr_data,
  output logic [BITS-1:0]           rd_data,
  output logic [ptr_w(DEPTH)-1:0]   level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [BITS-1:0] mem_q [DEPTH];
  logic [BITS-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign level   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fir_sample_sched.sv
// Feeds queued samples to the FIR core one at a time. Optional done-timeout
// watchdog is built only when FIR_SCHED_TIMEOUT_EN is defined.
//   state | meaning
//   IDLE  | nothing in flight, waiting for a queued sample
//   START | fir_start pulse cycle, fir_x just loaded
//   BUSY  | core computing, waiting for fir_done (or timeout)
module fir_sample_sched
  import fir_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  fir_sample_sched_if.slave        bus,
  output logic                     busy,
  output logic [ptr_w(DEPTH)-1:0]  level,
  output logic [OUT_CNT_W-1:0]     out_cnt,
  output logic                     err_timeout
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fir_sample_sched: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("fir_sample_sched: TIMEOUT must be >= 2");
  end

  sched_state_e           state_q, state_d;
  logic [BITS-1:0]        x_q, x_d;
  logic [OUT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   push, pop, has_data, leave_busy;
  logic [BITS-1:0]        head;

`ifdef FIR_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
  logic          expire;
`endif

  assign bus.in_ready = (level != FULL_LVL);
  assign push         = bus.in_valid && bus.in_ready;
  assign has_data     = (level != '0);

  sync_fifo #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.in_data),
    .rd_data (head),
    .level   (level)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    leave_busy = 1'b0;
`ifdef FIR_SCHED_TIMEOUT_EN
    tmr_d      = tmr_q;
    err_d      = err_q;
    expire     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (has_data) begin
          pop     = 1'b1;
          x_d     = head;
          state_d = START;
        end
      end
      START: begin
        state_d = BUSY;
`ifdef FIR_SCHED_TIMEOUT_EN
        // Down-count from TIMEOUT-1: terminal count hits on the TIMEOUT-th BUSY cycle.
        tmr_d   = TW'(TIMEOUT - 1);
`endif
      end
      BUSY: begin
        leave_busy = bus.fir_done;
`ifdef FIR_SCHED_TIMEOUT_EN
        tmr_d  = tmr_q - 1'b1;
        expire = (tmr_q == '0) && !bus.fir_done;
        if (expire) err_d = 1'b1;
        leave_busy = bus.fir_done || expire;
`endif
        if (bus.fir_done) cnt_d = cnt_q + 1'b1;
        if (leave_busy) begin
          if (has_data) begin
            pop     = 1'b1;
            x_d     = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
`ifdef FIR_SCHED_TIMEOUT_EN
      tmr_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
`ifdef FIR_SCHED_TIMEOUT_EN
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.fir_start = (state_q == START);
  assign bus.fir_x     = x_q;
  assign busy          = (state_q != IDLE);
  assign out_cnt       = cnt_q;
`ifdef FIR_SCHED_TIMEOUT_EN
  assign err_timeout   = err_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sample_sched.sv
// Directed bench for fir_sample_sched: cycle table for single-sample and fill,
// hand sequences for back-to-back, spurious done, reset mid-BUSY and timeout.
module tb_fir_sample_sched;

  localparam int BITS    = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int LAT     = 3;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [2:0]  level;
  logic [15:0] out_cnt;
  logic        err_timeout;

  int n_checks = 0;
  int n_err    = 0;

  fir_sample_sched_if #(.BITS(BITS)) bus ();

  fir_sample_sched #(
    .BITS    (BITS),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .level       (level),
    .out_cnt     (out_cnt),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        vld;
    logic [7:0]  dat;
    logic        done;
    logic        e_start;
    logic [7:0]  e_x;
    logic        e_busy;
    logic [2:0]  e_lvl;
    logic        e_rdy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic chk_out(input string n, input logic s, input logic [7:0] x, input logic b,
                         input logic [2:0] l, input logic [15:0] c);
    chk({n, ".start"}, 32'(bus.fir_start), 32'(s));
    chk({n, ".x"},     32'(bus.fir_x),     32'(x));
    chk({n, ".busy"},  32'(busy),          32'(b));
    chk({n, ".level"}, 32'(level),         32'(l));
    chk({n, ".cnt"},   32'(out_cnt),       32'(c));
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic dn);
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.fir_done = dn;
  endtask

  initial begin
    logic [7:0] b2b_exp [3];
    b2b_exp[0] = 8'h03; b2b_exp[1] = 8'h04; b2b_exp[2] = 8'h05;

    drive(1'b1, 1'b0, 8'h00, 1'b0);

    //               name            rst   vld   dat    done  start x      busy  lvl   rdy   cnt
    vecs.push_back('{"reset",        1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 16'd0});
    vecs.push_back('{"push_5a",      1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1, 16'd0});
    vecs.push_back('{"start_5a",     1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 3'd0, 1'b1, 16'd0});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{"wait_5a",    1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 3'd0, 1'b1, 16'd0});
    vecs.push_back('{"done_5a",      1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 3'd0, 1'b1, 16'd1});
    vecs.push_back('{"idle_hold",    1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 3'd0, 1'b1, 16'd1});
    vecs.push_back('{"push_01",      1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h5A, 1'b0, 3'd1, 1'b1, 16'd1});
    vecs.push_back('{"push_02",      1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b1, 3'd1, 1'b1, 16'd1});
    vecs.push_back('{"push_03",      1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h01, 1'b1, 3'd2, 1'b1, 16'd1});
    vecs.push_back('{"push_04",      1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 8'h01, 1'b1, 3'd3, 1'b1, 16'd1});
    vecs.push_back('{"push_05_full", 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h01, 1'b1, 3'd4, 1'b0, 16'd1});
    vecs.push_back('{"full_pushpop", 1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 8'h02, 1'b1, 3'd3, 1'b1, 16'd2});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].dat, vecs[i].done);
      step();
      chk_out(vecs[i].name, vecs[i].e_start, vecs[i].e_x, vecs[i].e_busy, vecs[i].e_lvl, vecs[i].e_cnt);
      chk({vecs[i].name, ".ready"}, 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      chk({vecs[i].name, ".err"},   32'(err_timeout),  32'd0);
    end

    // back-to-back: done LAT cycles after each start, next start the cycle after done
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < LAT; j++) begin
        step();
        chk("b2b.gap_start", 32'(bus.fir_start), 32'd0);
      end
      bus.fir_done = 1'b1;
      step();
      bus.fir_done = 1'b0;
      chk_out("b2b", 1'b1, b2b_exp[k], 1'b1, 3'(2 - k), 16'(3 + k));
    end
    for (int j = 0; j < LAT; j++) step();
    bus.fir_done = 1'b1;
    step();
    bus.fir_done = 1'b0;
    chk_out("b2b_last", 1'b0, 8'h05, 1'b0, 3'd0, 16'd6);
    step();
    chk_out("no_06", 1'b0, 8'h05, 1'b0, 3'd0, 16'd6);

    // done outside BUSY must not count
    bus.fir_done = 1'b1;
    step();
    bus.fir_done = 1'b0;
    chk_out("spur_idle", 1'b0, 8'h05, 1'b0, 3'd0, 16'd6);
    drive(1'b0, 1'b1, 8'h77, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    chk_out("start_77", 1'b1, 8'h77, 1'b1, 3'd0, 16'd6);
    bus.fir_done = 1'b1;
    step();
    chk_out("spur_start", 1'b0, 8'h77, 1'b1, 3'd0, 16'd6);
    step();
    bus.fir_done = 1'b0;
    chk_out("done_77", 1'b0, 8'h77, 1'b0, 3'd0, 16'd7);

    // reset while BUSY with three samples queued
    drive(1'b0, 1'b1, 8'h11, 1'b0); step();
    drive(1'b0, 1'b1, 8'h22, 1'b0); step();
    drive(1'b0, 1'b1, 8'h33, 1'b0); step();
    drive(1'b0, 1'b1, 8'h44, 1'b0); step();
    chk_out("pre_rst", 1'b0, 8'h11, 1'b1, 3'd3, 16'd7);
    drive(1'b1, 1'b0, 8'h00, 1'b0); step();
    chk_out("mid_rst", 1'b0, 8'h00, 1'b0, 3'd0, 16'd0);
    chk("mid_rst.ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    chk_out("post_rst_done", 1'b0, 8'h00, 1'b0, 3'd0, 16'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0); step();
    chk_out("post_rst_idle", 1'b0, 8'h00, 1'b0, 3'd0, 16'd0);

`ifdef FIR_SCHED_TIMEOUT_EN
    // done on the expiry cycle wins: no error, counted
    drive(1'b0, 1'b1, 8'hA1, 1'b0); step();
    drive(1'b0, 1'b1, 8'hB2, 1'b0); step();
    drive(1'b0, 1'b1, 8'hC3, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int j = 0; j < TIMEOUT - 1; j++) step();
    chk("to_edge.err", 32'(err_timeout), 32'd0);
    bus.fir_done = 1'b1;
    step();
    bus.fir_done = 1'b0;
    chk_out("to_edge_done", 1'b1, 8'hB2, 1'b1, 3'd1, 16'd1);
    chk("to_edge_done.err", 32'(err_timeout), 32'd0);
    // withhold done: expire after the TIMEOUT-th BUSY cycle
    step();
    for (int j = 0; j < TIMEOUT - 1; j++) begin
      step();
      chk("to_wait.err", 32'(err_timeout), 32'd0);
    end
    step();
    chk_out("to_expire", 1'b1, 8'hC3, 1'b1, 3'd0, 16'd1);
    chk("to_expire.err", 32'(err_timeout), 32'd1);
    bus.fir_done = 1'b1;
    step(); step();
    bus.fir_done = 1'b0;
    chk_out("to_sticky", 1'b0, 8'hC3, 1'b0, 3'd0, 16'd2);
    chk("to_sticky.err", 32'(err_timeout), 32'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("to_rst.err", 32'(err_timeout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
